// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute/memory boundary:
//   - conditional-branch funct3 encodings
//   - skid-stage state encodings
//   - width of the buffered instruction bundle
// No ports (package).
// ----------------------------------------------------------------------------
package ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    // Branch funct3 encodings (RV32 conditional branches)
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Skid-stage occupancy states
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Bundle = result + store data + branch target + rd + 3 control bits + taken
    function automatic int bundle_w(input int xlen, input int regw);
        return (3 * xlen) + regw + 4;
    endfunction

    localparam int BUNDLE_W = bundle_w(XLEN_DEF, REGW_DEF);

endpackage

// File: rtl/br_cond_eval.sv
// ----------------------------------------------------------------------------
// br_cond_eval
// Combinational decode of a conditional-branch condition from ALU flags.
// Ports:
//   funct3_i  branch type
//   z_i, s_i, c_i, v_i  ALU flags (c_i=1 means no borrow, a>=b unsigned)
//   cond_o    condition true (unqualified by branch-enable)
// ----------------------------------------------------------------------------
module br_cond_eval
    import ex_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       z_i,
    input  logic       s_i,
    input  logic       c_i,
    input  logic       v_i,
    output logic       cond_o
);

    // Flag decode per branch type; reserved encodings never take
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            BR_BEQ:  cond_o = z_i;
            BR_BNE:  cond_o = ~z_i;
            BR_BLT:  cond_o = s_i ^ v_i;
            BR_BGE:  cond_o = ~(s_i ^ v_i);
            BR_BLTU: cond_o = ~c_i;
            BR_BGEU: cond_o = c_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_skid_stage
// Execute-to-memory boundary register with a two-entry skid buffer (head M,
// skid S). in_ready is registered so memory back-pressure never reaches the
// execute stage combinationally. Branch outcome is resolved at capture.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      execute-side handshake
//   alu_result, z,s,c,v      ALU result and flags
//   rd, reg_wr, mem_rd, mem_wr, store_data   control bundle
//   br_en, br_funct3, br_target              branch info
//   flush                    discard all buffered beats
//   out_valid / out_ready    memory-side handshake
//   out_*                    head-entry fields, out_br_taken resolved branch
//   prev_res                 last accepted alu_result
//
// Optional build macro EX_STALL_CNT_EN adds:
//   stall_cnt     cycles with in_valid & !in_ready
//   br_taken_cnt  taken branches delivered to the memory stage
// ----------------------------------------------------------------------------
module ex_mem_skid_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            z,
    input  logic            s,
    input  logic            c,
    input  logic            v,
    input  logic [REGW-1:0] rd,
    input  logic            reg_wr,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [XLEN-1:0] store_data,
    input  logic            br_en,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_br_target,
    output logic [REGW-1:0] out_rd,
    output logic            out_reg_wr,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_br_taken,
    output logic [XLEN-1:0] prev_res
`ifdef EX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     br_taken_cnt
`endif
);

    localparam int BW     = bundle_w(XLEN, REGW);
    // Bundle field offsets: {result, store_data, br_target, rd, reg_wr, mem_rd, mem_wr, taken}
    localparam int TK_B   = 0;
    localparam int MW_B   = 1;
    localparam int MR_B   = 2;
    localparam int RW_B   = 3;
    localparam int RD_LO  = 4;
    localparam int TGT_LO = RD_LO + REGW;
    localparam int SD_LO  = TGT_LO + XLEN;
    localparam int RES_LO = SD_LO + XLEN;

    state_e          state_q, state_d;
    logic [BW-1:0]   m_q, m_d;
    logic [BW-1:0]   s_q, s_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            br_taken_q, br_taken_d;
    logic [XLEN-1:0] prev_res_q, prev_res_d;
    logic            cond_s;
    logic            accept_s;
    logic [BW-1:0]   in_bundle_s;

    br_cond_eval u_br_cond_eval (
        .funct3_i (br_funct3),
        .z_i      (z),
        .s_i      (s),
        .c_i      (c),
        .v_i      (v),
        .cond_o   (cond_s)
    );

    assign accept_s    = in_valid & in_ready_q & ~flush;
    assign in_bundle_s = {alu_result, store_data, br_target, rd,
                          reg_wr, mem_rd, mem_wr, br_en & cond_s};

    // Occupancy FSM next-state and entry moves; flush overrides everything
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        m_d     = in_bundle_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && out_ready) begin
                        state_d = ST_ONE;
                        m_d     = in_bundle_s;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                        s_d     = in_bundle_s;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can coincide with the drain
                    if (out_ready) begin
                        state_d = ST_ONE;
                        m_d     = s_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Registered handshake/status values derived from the next state
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        br_taken_d  = (state_d != ST_EMPTY) & m_d[TK_B];
        if (accept_s) begin
            prev_res_d = alu_result;
        end else begin
            prev_res_d = prev_res_q;
        end
    end

    // State, buffer entries and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= {BW{1'b0}};
            s_q         <= {BW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
            prev_res_q  <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            br_taken_q  <= br_taken_d;
            prev_res_q  <= prev_res_d;
        end
    end

`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] br_taken_cnt_q;

    // Stall and delivered-taken-branch counters; cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= 32'd0;
            br_taken_cnt_q <= 32'd0;
        end else begin
            if (in_valid && !in_ready_q) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (out_valid_q && out_ready && br_taken_q) begin
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
            end else begin
                br_taken_cnt_q <= br_taken_cnt_q;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_br_taken   = br_taken_q;
    assign out_result     = m_q[RES_LO +: XLEN];
    assign out_store_data = m_q[SD_LO +: XLEN];
    assign out_br_target  = m_q[TGT_LO +: XLEN];
    assign out_rd         = m_q[RD_LO +: REGW];
    assign out_reg_wr     = m_q[RW_B];
    assign out_mem_rd     = m_q[MR_B];
    assign out_mem_wr     = m_q[MW_B];
    assign prev_res       = prev_res_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_skid_stage
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based model of a two-deep in-order buffer with registered in_ready.
// ----------------------------------------------------------------------------
module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        z, s, c, v;
    logic [4:0]  rd;
    logic        reg_wr, mem_rd, mem_wr;
    logic [31:0] store_data;
    logic        br_en;
    logic [2:0]  br_funct3;
    logic [31:0] br_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_store_data, out_br_target;
    logic [4:0]  out_rd;
    logic        out_reg_wr, out_mem_rd, out_mem_wr;
    logic        out_br_taken;
    logic [31:0] prev_res;
`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] br_taken_cnt;
`endif

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .z(z), .s(s), .c(c), .v(v),
        .rd(rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .br_en(br_en), .br_funct3(br_funct3),
        .br_target(br_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_br_target(out_br_target), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_br_taken(out_br_taken), .prev_res(prev_res)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .br_taken_cnt(br_taken_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        tk;
    } beat_t;

    beat_t       q[$];
    logic        exp_ready = 1'b0;
    logic [31:0] exp_prev  = 32'd0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_btc   = 32'd0;
    int          checks = 0;
    int          errors = 0;

    // Branch rule table from the instruction set definition
    function automatic logic branch_cond(input logic [2:0] f, input logic fz,
                                         input logic fs, input logic fc, input logic fv);
        if (f == 3'd0)      return fz;
        else if (f == 3'd1) return !fz;
        else if (f == 3'd4) return (fs != fv);
        else if (f == 3'd5) return (fs == fv);
        else if (f == 3'd6) return !fc;
        else if (f == 3'd7) return fc;
        else                return 1'b0;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] out_fields();
        return {out_result, out_store_data, out_br_target, out_rd,
                out_reg_wr, out_mem_rd, out_mem_wr};
    endfunction

    task automatic rand_fields();
        alu_result = $urandom;
        store_data = $urandom;
        br_target  = $urandom;
        rd         = 5'($urandom_range(0, 31));
        {z, s, c, v} = 4'($urandom_range(0, 15));
        {reg_wr, mem_rd, mem_wr} = 3'($urandom_range(0, 7));
        br_en      = 1'($urandom_range(0, 1));
        br_funct3  = 3'($urandom_range(0, 7));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        beat_t nb;
        beat_t hd;
        logic  acc;
        @(posedge clk);
        nb = '{res: alu_result, sd: store_data, tgt: br_target, rd: rd,
               rw: reg_wr, mr: mem_rd, mw: mem_wr,
               tk: br_en & branch_cond(br_funct3, z, s, c, v)};
        if (rst) begin
            q.delete();
            exp_ready = 1'b0;
            exp_prev  = 32'd0;
            exp_stall = 32'd0;
            exp_btc   = 32'd0;
        end else begin
            acc = in_valid & exp_ready & !flush;
            if (in_valid && !exp_ready) exp_stall = exp_stall + 32'd1;
            if (q.size() > 0 && out_ready && q[0].tk) exp_btc = exp_btc + 32'd1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(nb);
            end
            if (acc) exp_prev = alu_result;
            exp_ready = (q.size() < 2);
        end
        #1;
        chk1("in_ready", in_ready, exp_ready);
        chk1("out_valid", out_valid, q.size() > 0);
        chk32("prev_res", prev_res, exp_prev);
        if (q.size() > 0) begin
            hd = q[0];
            chkb("head_fields", out_fields(), hd[104:1]);
            chk1("out_br_taken", out_br_taken, hd.tk);
        end else begin
            chk1("out_br_taken_idle", out_br_taken, 1'b0);
        end
`ifdef EX_STALL_CNT_EN
        chk32("stall_cnt", stall_cnt, exp_stall);
        chk32("br_taken_cnt", br_taken_cnt, exp_btc);
`endif
    endtask

    logic [31:0] saved_prev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rand_fields();
        tick();
        tick();
        chkb("reset_fields", out_fields(), 104'd0);
        chk1("reset_in_ready", in_ready, 1'b0);

        rst = 1'b0;
        tick();
        chk1("post_reset_in_ready", in_ready, 1'b1);

        // Free flow
        out_ready = 1'b1;
        in_valid = 1'b1; rand_fields(); br_en = 1'b0; alu_result = 32'h0000_0005;
        tick();
        chk32("flow_first", out_result, 32'h0000_0005);
        rand_fields(); alu_result = 32'h0000_000A;
        tick();
        chk32("flow_second", out_result, 32'h0000_000A);
        chk1("flow_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();
        chk32("flow_prev", prev_res, 32'h0000_000A);

        // Skid fill and ordered drain
        out_ready = 1'b0;
        in_valid = 1'b1; rand_fields(); alu_result = 32'h11;
        tick();
        rand_fields(); alu_result = 32'h22;
        tick();
        chk1("full_ready", in_ready, 1'b0);
        chk32("full_head", out_result, 32'h11);
        in_valid = 1'b0;
        tick();
        chk32("full_hold", out_result, 32'h11);
        out_ready = 1'b1;
        tick();
        chk32("drain_second", out_result, 32'h22);
        chk1("drain_ready", in_ready, 1'b1);
        tick();
        chk1("drain_empty", out_valid, 1'b0);

        // Branch decode
        in_valid = 1'b1; rand_fields();
        br_en = 1'b1; br_funct3 = 3'b100; s = 1'b1; v = 1'b0;
        tick();
        chk1("blt_taken", out_br_taken, 1'b1);
        rand_fields(); br_en = 1'b1; br_funct3 = 3'b111; c = 1'b0;
        tick();
        chk1("bgeu_not_taken", out_br_taken, 1'b0);
        rand_fields(); br_en = 1'b0; br_funct3 = 3'b000; z = 1'b1;
        tick();
        chk1("beq_disabled", out_br_taken, 1'b0);

        // Flush while FULL with a beat offered
        out_ready = 1'b0; rand_fields();
        tick();
        rand_fields();
        tick();
        saved_prev = prev_res;
        rand_fields(); alu_result = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        chk1("flush_full_valid", out_valid, 1'b0);
        chk32("flush_full_prev", prev_res, saved_prev);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk1("flush_no_ghost", out_valid, 1'b0);

        // Flush while ONE: the offered beat is dropped despite in_ready
        in_valid = 1'b1; out_ready = 1'b0; rand_fields();
        tick();
        saved_prev = prev_res;
        rand_fields(); flush = 1'b1;
        tick();
        chk1("flush_one_valid", out_valid, 1'b0);
        chk32("flush_one_prev", prev_res, saved_prev);
        flush = 1'b0; in_valid = 1'b0;
        tick();

        // Reset in the middle of FULL
        in_valid = 1'b1; rand_fields();
        tick();
        rand_fields();
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chkb("rst_mid_fields", out_fields(), 104'd0);
        chk1("rst_mid_ready", in_ready, 1'b0);
        chk32("rst_mid_prev", prev_res, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk1("rst_after_ready", in_ready, 1'b1);
        chk1("rst_after_valid", out_valid, 1'b0);

`ifdef EX_STALL_CNT_EN
        // Stall and taken-branch counters
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        tick();
        in_valid = 1'b1; rand_fields(); br_en = 1'b1; br_funct3 = 3'b000; z = 1'b1;
        tick();
        rand_fields(); br_en = 1'b1; br_funct3 = 3'b000; z = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            rand_fields();
            tick();
        end
        chk32("stall_cnt_7", stall_cnt, 32'd7);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk32("br_taken_cnt_2", br_taken_cnt, 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rand_fields();
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk1("final_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Execute-to-memory boundary register placed directly downstream of the ALU.
- Captures the ALU result, flags and control bundle of each instruction; resolves the conditional-branch outcome from the flags; feeds the memory stage over a valid/ready handshake.
- A two-entry skid buffer keeps a registered in_ready, so memory-stage back-pressure never forms a combinational path into execute.
- Also drives prev_res, the last accepted ALU result, back into the ALU's pass-through operand.

Parameters:
- XLEN, 32, datapath width of result, store data and branch target.
- REGW, 5, destination-register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute has a beat
- in_ready  out  1  stage can accept
- alu_result  in  XLEN  ALU result
- z,s,c,v  in  1 each  ALU flags; c=1 means no borrow (a>=b unsigned) on compare ops
- rd  in  REGW  destination register
- reg_wr, mem_rd, mem_wr  in  1 each  control bits
- store_data  in  XLEN  rs2 value for stores
- br_en  in  1  instruction is a conditional branch
- br_funct3  in  3  branch type
- br_target  in  XLEN  computed target
- flush  in  1  kill all buffered beats
- out_valid  out  1  beat available to memory stage
- out_ready  in  1  memory stage accepts
- out_result, out_store_data, out_br_target  out  XLEN  buffered fields
- out_rd  out  REGW
- out_reg_wr, out_mem_rd, out_mem_wr  out  1 each
- out_br_taken  out  1  branch resolved taken for the head beat
- prev_res  out  XLEN  last accepted alu_result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Storage: head entry M (drives all out_* ports) and skid entry S. Each holds the full bundle plus the resolved taken bit.
- Accept: a beat is accepted when in_valid & in_ready & !flush.
- in_ready is registered and equals !S_valid. It is 0 while rst is high and 1 on the first cycle after reset.
- Latency: a beat accepted in cycle n appears on out_* in cycle n+1.
- Branch resolution happens at capture. taken = br_en & cond, where cond is:
  - 000 BEQ: z
  - 001 BNE: !z
  - 100 BLT: s^v
  - 101 BGE: !(s^v)
  - 110 BLTU: !c
  - 111 BGEU: c
  - 010 and 011: 0
- out_br_taken = out_valid & M.taken.
- States:
  - EMPTY: M and S invalid.
    - Accept -> ONE, M<=in.
  - ONE: M valid.
    - Accept & out_ready -> ONE, M<=in.
    - Accept & !out_ready -> FULL, S<=in.
    - No accept & out_ready -> EMPTY.
    - Otherwise hold.
  - FULL: M and S valid, in_ready=0.
    - out_ready -> ONE, M<=S.
    - Otherwise hold.
- Stability: while out_valid & !out_ready, every out_* field holds its value.
- flush has priority over accept and drain. Next state is EMPTY and out_valid=0 next cycle; the in beat in the same cycle is dropped; prev_res is unchanged.
- prev_res loads alu_result on every accept and holds otherwise.
- Reset values: out_valid=0, in_ready=0, all out_* fields 0, prev_res=0, state EMPTY.
- Reset mid-operation discards M and S; no beat emerges afterwards.
- No arithmetic beyond the flag decode; all fields are passed through unmodified at full width.

Optional Feature:
- Macro: EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits. It increments each cycle with in_valid & !in_ready & !rst, wraps at 2^32, and is cleared by rst only (not by flush).
  - Adds output br_taken_cnt, 32 bits. It counts out_valid & out_ready & out_br_taken, wraps, and is cleared by rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package ex_pkg holds:
  - Branch funct3 constants: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - State encodings: ST_EMPTY, ST_ONE, ST_FULL.
  - The bundle width constant.
- One sub-module: br_cond_eval, a combinational decode of (funct3, z, s, c, v) to cond. It is reusable by a future early-branch stage.

Test Plan:
1. Free flow: out_ready=1; feed result 0x00000005, then 0x0000000A on consecutive cycles -> each appears one cycle later; in_ready stays 1; prev_res=0x0000000A.
2. Skid fill: out_ready=0; accept 0x11 then 0x22 -> state FULL, in_ready=0 next cycle, out_result holds 0x11. Raise out_ready -> 0x11 then 0x22 drain in order; in_ready returns to 1.
3. Branch decode: br_en=1 with BLT, s=1, v=0 -> out_br_taken=1. BGEU with c=0 -> 0. br_en=0 with z=1 under BEQ -> 0.
4. Flush in FULL with in_valid=1: next cycle out_valid=0, state EMPTY; the flushed beats and the input beat never appear; prev_res unchanged.
5. Reset mid-FULL: assert rst one cycle -> all outputs 0, in_ready=0 during rst, 1 the cycle after; no stale beat appears.
6. With EX_STALL_CNT_EN: hold FULL with in_valid=1 for 7 cycles -> stall_cnt=7. Two taken branches drained -> br_taken_cnt=2.
